systolic_feed_ctrl: RTL and testbench

Sequencer for the N x N systolic MAC array. It holds operand matrices A and B in internal register buffers, loaded through a simple write port. On start, it clears the array and streams row-skewed A and column-skewed B into the array edge inputs. It then waits for the pipeline to drain and pulses done when every C[i][j] in the array is final.

---
 rtl/systolic_feed_ctrl.sv | 178 +++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
//   Sequencer for an N x N output-stationary systolic MAC array.
//   Operand matrices A and B live in internal register buffers that are
//   written through a simple element write port while idle.
//   On start the controller:
//     1. pulses mac_clr to clear the array,
//     2. streams row-skewed A and column-skewed B onto the edge lanes,
//     3. waits drain_cycles for the last accumulate to settle,
//     4. pulses done and raises result_valid.
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous, active-low reset
//   start        : run request, sampled only in IDLE
//   wr_en        : buffer write strobe (honoured only in IDLE)
//   wr_sel       : 0 = A buffer, 1 = B buffer
//   wr_row       : element row index (values >= array_size are ignored)
//   wr_col       : element column index (values >= array_size are ignored)
//   wr_data      : element value
//   a_out        : A lanes; lane i = a_out[i*data_size +: data_size]
//   b_out        : B lanes; lane j = b_out[j*data_size +: data_size]
//   mac_clr      : active-high array clear
//   busy         : high while a run is in progress
//   done         : one-cycle pulse when every C[i][j] is final
//   result_valid : level; set with done, cleared by the next accepted start
//
// All outputs are registered from the current state, so they trail the
// state register by one edge (start at edge 0 -> mac_clr after edge 1).
// array_size must be at least 2.
module systolic_feed_ctrl #(
    parameter int array_size   = 3,
    parameter int data_size    = 8,
    parameter int drain_cycles = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                wr_en,
    input  logic                                wr_sel,
    input  logic [$clog2(array_size)-1:0]       wr_row,
    input  logic [$clog2(array_size)-1:0]       wr_col,
    input  logic [data_size-1:0]                wr_data,
    output logic [array_size*data_size-1:0]     a_out,
    output logic [array_size*data_size-1:0]     b_out,
    output logic                                mac_clr,
    output logic                                busy,
    output logic                                done,
    output logic                                result_valid
);

    localparam int IDX_W   = $clog2(array_size);
    localparam int STEPS   = 3 * array_size - 2;
    localparam int STEP_W  = $clog2(3 * array_size);
    localparam int DRAIN_W = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
    localparam int LANE_W  = array_size * data_size;

    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(drain_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [STEP_W-1:0]    step, step_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;

    logic [LANE_W-1:0]    a_nxt, b_nxt;
    logic                 mac_clr_nxt, busy_nxt, done_nxt, rv_nxt;

    logic [data_size-1:0] a_buf [array_size][array_size];
    logic [data_size-1:0] b_buf [array_size][array_size];

    int                   k;

    // Operand buffers: writable only in IDLE, frozen for the whole run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 0; r < array_size; r++) begin
                for (int unsigned c = 0; c < array_size; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else if (state == IDLE && wr_en &&
                     int'(wr_row) < array_size && int'(wr_col) < array_size) begin
            if (wr_sel)
                b_buf[wr_row][wr_col] <= wr_data;
            else
                a_buf[wr_row][wr_col] <= wr_data;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            step         <= '0;
            drain_cnt    <= '0;
            a_out        <= '0;
            b_out        <= '0;
            mac_clr      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            step         <= step_nxt;
            drain_cnt    <= drain_nxt;
            a_out        <= a_nxt;
            b_out        <= b_nxt;
            mac_clr      <= mac_clr_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            result_valid <= rv_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        drain_nxt   = drain_cnt;
        a_nxt       = '0;
        b_nxt       = '0;
        mac_clr_nxt = 1'b0;
        busy_nxt    = 1'b1;
        done_nxt    = 1'b0;
        rv_nxt      = result_valid;
        k           = 0;

        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt = CLEAR;
                    rv_nxt    = 1'b0;
                end
            end
            CLEAR: begin
                mac_clr_nxt = 1'b1;
                step_nxt    = '0;
                state_nxt   = FEED;
            end
            FEED: begin
                // Lane i carries A[i][t-i]; lane j carries B[t-j][j]. Lanes
                // whose diagonal index is outside 0..N-1 stay zero.
                for (int unsigned i = 0; i < array_size; i++) begin
                    k = int'(step) - int'(i);
                    if (k >= 0 && k < array_size) begin
                        a_nxt[i*data_size +: data_size] = a_buf[IDX_W'(i)][IDX_W'(k)];
                        b_nxt[i*data_size +: data_size] = b_buf[IDX_W'(k)][IDX_W'(i)];
                    end
                end
                step_nxt = step + STEP_W'(1);
                if (step == STEP_LAST) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end
            end
            DRAIN: begin
                drain_nxt = drain_cnt + DRAIN_W'(1);
                if (drain_cnt == DRAIN_LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                rv_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

    localparam int N      = 3;
    localparam int W      = 8;
    localparam int D      = 1;
    localparam int IW     = $clog2(N);
    localparam int CW     = 2 * W;
    localparam int STEPS  = 3 * N - 2;
    localparam int DONE_E = 3 * N + D;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [IW-1:0] wr_row = '0;
    logic [IW-1:0] wr_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic [N*W-1:0] a_out, b_out;
    logic          mac_clr, busy, done, result_valid;

    systolic_feed_ctrl #(
        .array_size  (N),
        .data_size   (W),
        .drain_cycles(D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .a_out       (a_out),
        .b_out       (b_out),
        .mac_clr     (mac_clr),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
    } feed_t;

    feed_t        sb[$];
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    int           n_cmp = 0;
    int           n_mis = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input bit sel, input int row, input int col, input int val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(row);
        wr_col  = IW'(col);
        wr_data = W'(val);
        tick();
        wr_en = 1'b0;
        if (row < N && col < N) begin
            if (sel) mb[row][col] = W'(val);
            else     ma[row][col] = W'(val);
        end
    endtask

    task automatic zero_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
    endtask

    task automatic load_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_elem(1'b0, r, c, int'($urandom_range(0, 15)));
                write_elem(1'b1, r, c, int'($urandom_range(0, 15)));
            end
    endtask

    // Runs one multiply starting at edge 0 (start already driven or set here).
    // Expected feed steps go to the scoreboard up front; an output-stationary
    // array model consumes the DUT lanes and its C is compared to ma*mb.
    task automatic run_matmul(input string tag, input int abort_at, input int wr_at,
                              input int start_at, input bit keep_start);
        feed_t          f;
        logic [CW-1:0]  exp_c [N][N];
        logic [CW-1:0]  acc   [N][N];
        logic [W-1:0]   ar    [N][N];
        logic [W-1:0]   br    [N][N];
        logic [W-1:0]   ain, bin;
        bit             b_exp;

        for (int t = 0; t < STEPS; t++) begin
            f.a = '0;
            f.b = '0;
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) begin
                    f.a[i*W +: W] = ma[i][t-i];
                    f.b[i*W +: W] = mb[t-i][i];
                end
            sb.push_back(f);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = '0;
                for (int q = 0; q < N; q++)
                    exp_c[i][j] = exp_c[i][j] + CW'(ma[i][q]) * CW'(mb[q][j]);
                acc[i][j] = '1;
                ar[i][j]  = '0;
                br[i][j]  = '0;
            end

        start = 1'b1;
        for (int e = 0; e <= DONE_E; e++) begin
            tick();
            if (!keep_start) start = 1'b0;
            wr_en = 1'b0;

            if (e == abort_at) begin
                n_cmp++;
                if (a_out !== '0 || b_out !== '0 || busy !== 1'b0 || done !== 1'b0 ||
                    result_valid !== 1'b0 || mac_clr !== 1'b1) begin
                    n_mis++;
                    $display("FAIL %s abort_outputs: a=%h b=%h busy=%b done=%b rv=%b clr=%b, want a=0 b=0 busy=0 done=0 rv=0 clr=1",
                             tag, a_out, b_out, busy, done, result_valid, mac_clr);
                end
                sb.delete();
                return;
            end

            b_exp = (e >= 1 && e <= DONE_E);
            n_cmp++;
            if (busy !== b_exp) begin
                n_mis++;
                $display("FAIL %s busy@edge%0d: got %b want %b", tag, e, busy, b_exp);
            end
            n_cmp++;
            if (done !== (e == DONE_E)) begin
                n_mis++;
                $display("FAIL %s done@edge%0d: got %b want %b", tag, e, done, e == DONE_E);
            end
            n_cmp++;
            if (mac_clr !== (e == 1)) begin
                n_mis++;
                $display("FAIL %s mac_clr@edge%0d: got %b want %b", tag, e, mac_clr, e == 1);
            end
            n_cmp++;
            if (result_valid !== (e == DONE_E)) begin
                n_mis++;
                $display("FAIL %s result_valid@edge%0d: got %b want %b", tag, e, result_valid, e == DONE_E);
            end

            if (e >= 2 && e < 2 + STEPS) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL %s scoreboard_empty@edge%0d: got 0 entries want 1", tag, e);
                end else begin
                    f = sb.pop_front();
                    n_cmp++;
                    if (a_out !== f.a || b_out !== f.b) begin
                        n_mis++;
                        $display("FAIL %s feed_t%0d: got a=%h b=%h want a=%h b=%h",
                                 tag, e - 2, a_out, b_out, f.a, f.b);
                    end
                end
            end else begin
                n_cmp++;
                if (a_out !== '0 || b_out !== '0) begin
                    n_mis++;
                    $display("FAIL %s idle_lanes@edge%0d: got a=%h b=%h want 0", tag, e, a_out, b_out);
                end
            end

            if (mac_clr) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] = '0;
                        ar[i][j]  = '0;
                        br[i][j]  = '0;
                    end
            end else begin
                for (int i = N - 1; i >= 0; i--)
                    for (int j = N - 1; j >= 0; j--) begin
                        ain = (j == 0) ? a_out[i*W +: W] : ar[i][j-1];
                        bin = (i == 0) ? b_out[j*W +: W] : br[i-1][j];
                        acc[i][j] = acc[i][j] + CW'(ain) * CW'(bin);
                        ar[i][j]  = ain;
                        br[i][j]  = bin;
                    end
            end

            if (e + 1 == abort_at) rst = 1'b0;
            if (e + 1 == wr_at) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = '0;
                wr_col  = '0;
                wr_data = W'(99);
            end
            if (e + 1 == start_at) start = 1'b1;
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL %s scoreboard_leftover: got %0d entries want 0", tag, sb.size());
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (acc[i][j] !== exp_c[i][j]) begin
                    n_mis++;
                    $display("FAIL %s C[%0d][%0d]: got %0d want %0d", tag, i, j, acc[i][j], exp_c[i][j]);
                end
            end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || a_out !== '0 || b_out !== '0 ||
                mac_clr !== 1'b1 || result_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL reset_hold%0d: busy=%b done=%b a=%h b=%h clr=%b rv=%b, want 0 0 0 0 1 0",
                         c, busy, done, a_out, b_out, mac_clr, result_valid);
            end
        end
        rst   = 1'b1;
        start = 1'b0;
        tick();
        n_cmp++;
        if (mac_clr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_release: clr=%b busy=%b done=%b, want 0 0 0", mac_clr, busy, done);
        end
        zero_model();
    endtask

    task automatic test_skew();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_elem(1'b1, r, c, (r == c) ? 1 : 0);
                if (!(r == N - 1 && c == N - 1)) write_elem(1'b0, r, c, r * N + c + 1);
            end
        // Last A element written on the same edge start is sampled.
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = IW'(N - 1);
        wr_col  = IW'(N - 1);
        wr_data = W'(N * N);
        ma[N-1][N-1] = W'(N * N);
        run_matmul("skew", -1, -1, -1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (result_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                n_mis++;
                $display("FAIL skew_hold%0d: rv=%b done=%b busy=%b, want 1 0 0", c, result_valid, done, busy);
            end
        end
    endtask

    task automatic test_protection();
        load_random();
        run_matmul("prot", -1, 4, 3 * N, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || mac_clr !== 1'b0) begin
                n_mis++;
                $display("FAIL prot_no_rerun%0d: busy=%b done=%b clr=%b, want 0 0 0", c, busy, done, mac_clr);
            end
        end
        run_matmul("prot_rerun", -1, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        load_random();
        run_matmul("abort", 2 + 3 + 1, -1, -1, 1'b0);
        rst = 1'b1;
        zero_model();
        run_matmul("abort_zero", -1, -1, -1, 1'b0);
        tick();
        load_random();
        run_matmul("abort_reload", -1, -1, -1, 1'b0);
    endtask

    task automatic test_edge_cases();
        tick();
        write_elem(1'b0, 3, 0, 55);
        write_elem(1'b1, 0, 3, 66);
        write_elem(1'b0, 3, 3, 77);
        write_elem(1'b0, 1, 1, 12);
        run_matmul("bad_index", -1, -1, -1, 1'b0);
        tick();
        start = 1'b1;
        run_matmul("held_run0", -1, -1, -1, 1'b1);
        run_matmul("held_run1", -1, -1, -1, 1'b1);
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL held_stop: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    initial begin
        zero_model();
        test_reset();
        test_skew();
        test_protection();
        test_abort();
        test_edge_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
